multicycle_cpu: RTL and testbench
=================================

Name: multicycle_cpu

Overview:
- Multi-cycle successor to the single-cycle ARM-subset CPU top.
- Integrates a controller FSM and a shared datapath with one ALU, a register file and a single unified memory port. The memory port uses a req/ready handshake, so wait-states are tolerated.
- Parametrised in address width, reset vector and register count. Adds branches, conditional flag update and stall-on-memory, none of which the single-cycle top has.
- Exposes the last ALU result and the N/Z/CO/OVF flags at the top level.

Parameters:
- MEM_AW, 16, byte-address width of the memory port (word-aligned; bits [1:0] always 0).
- RESET_PC, 0, value loaded into the PC on reset (truncated to MEM_AW).
- NREG, 16, number of implemented registers, 2..16. Register indices >= NREG read 0 and ignore writes.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  MEM_AW  byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, sampled in the cycle mem_ready=1
- mem_ready  in  1  access completes in this cycle
- out  out  32  last ALU result register
- N, Z, CO, OVF  out  1 each  condition flags
- halted  out  1  HALT instruction executed

Behaviour:
- One clock; reset is synchronous and active-high. On reset:
  - PC=RESET_PC; all registers=0; out=0; N=Z=CO=OVF=0; halted=0.
  - mem_req=0, mem_we=0; state=FETCH.
  - Reset overrides a pending memory handshake, which is abandoned.
- Instruction format:
  - [27:26] op: 00 = data-processing (DP), 01 = memory (MEM), 10 = branch (B), 11 = HALT.
  - [25] I (immediate select).
  - [24:21] cmd: 0000 AND, 0010 SUB, 0100 ADD, 1100 ORR, 1101 MOV, 1010 CMP.
  - [20] S for DP; L for MEM (1 = load).
  - [19:16] Rn, [15:12] Rd.
  - Operand 2: I=1 uses imm8 [7:0] zero-extended; I=0 uses Rm [3:0].
  - MEM offset: imm12 [11:0], zero-extended, added to Rn.
  - B target: [23:0] imm24, sign-extended, <<2, added to PC+4.
  - Bits [31:28] are ignored.
  - An unlisted cmd executes as MOV with no register write.
- FSM states: FETCH, DECODE, EXEC, MEMACC, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: latch IR, PC<=PC+4, go to DECODE.
  - DECODE: read Rn and Rm/Rd into the A/B latches; go to EXEC, or to HALT if op=11.
  - EXEC, DP: compute ALU, latch out.
    - Flags update if S=1 or cmd=CMP.
    - Go to WB; CMP goes to FETCH instead, with no register write.
  - EXEC, MEM: compute address Rn+imm12 into the address latch; go to MEMACC.
  - EXEC, B: PC<=PC+sext(imm24)<<2, where PC already holds fetch address+4; go to FETCH.
  - MEMACC: mem_req=1; mem_we=~L; mem_addr=latched address; mem_wdata=Rd.
    - On mem_ready: a load latches rdata and goes to WB; a store goes to FETCH.
    - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ready.
  - WB: write Rd (ALU result or load data); go to FETCH.
  - HALT: terminal state; halted=1; mem_req=0. Only reset exits it.
- Cycle counts with zero-wait memory (mem_ready=1 in the first request cycle):
  - DP: 4 cycles; CMP: 3; load: 5; store: 4; branch: 3.
  - Each wait cycle adds 1.
- ALU and flags:
  - All arithmetic is 32-bit, two's complement.
  - N = result[31]; Z = (result == 0).
  - ADD: CO = carry out; OVF = signed overflow.
  - SUB/CMP: CO = NOT borrow (ARM convention; 5-3 gives CO=1, 3-5 gives CO=0); OVF = signed overflow.
  - AND/ORR/MOV: CO and OVF are left unchanged.
  - Flags never change when S=0 (except CMP).
- Boundaries:
  - PC wraps modulo 2^MEM_AW.
  - The low two address bits are forced to 0 on mem_addr.
  - R15 is an ordinary register; the PC is not mapped into the register file.
  - Rd=Rn within the same instruction is legal: the read happens before the write.

Test Plan:
- Reset then zero-wait program `MOV R1,#5; MOV R2,#3; SUB R3,R1,R2 (S=1)` -> out=2, R3=2, N=0, Z=0, CO=1, OVF=0; PC=RESET_PC+12 after 11 cycles.
- `CMP R2,R1` (3 vs 5) -> N=1, Z=0, CO=0, OVF=0; R-file unchanged; out=0xFFFFFFFE.
- `ADD` with S=1 of 0x7FFFFFFF and imm 1 -> out=0x80000000, N=1, OVF=1, CO=0. Repeat with S=0 -> flags hold previous values.
- Store R3 to [R0+8], then load into R4, with mem_ready delayed 3 cycles per access -> mem_addr/mem_we/mem_wdata stable during the wait; R4=2; each access costs +3 cycles.
- Branch with imm24=-2 at address 0x10 -> next fetch at 0x0C. Branch at PC near 2^MEM_AW-4 with a positive offset -> address wraps.
- HALT -> halted=1, mem_req=0 indefinitely. Assert reset mid-MEMACC (mem_req=1, ready=0) -> next cycle mem_req=0, PC=RESET_PC, flags=0, halted=0.

Source files
------------

// File: rtl/multicycle_cpu.sv
// Multi-cycle ARM-subset CPU: controller FSM around a shared datapath with one
// ALU, a register file and a single req/ready memory port that tolerates wait-states.
module multicycle_cpu #(
  parameter int          MEM_AW   = 16,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          NREG     = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       out,
  output logic              N,
  output logic              Z,
  output logic              CO,
  output logic              OVF,
  output logic              halted
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEMACC = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  logic [2:0]        state_q, state_d;
  logic [MEM_AW-1:0] pc_q, pc_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       out_q, out_d;
  logic [3:0]        flags_q, flags_d;  // {N, Z, CO, OVF}
  logic [31:0]       rf_q [NREG];

  logic [1:0]  op;
  logic        i_bit, s_bit;
  logic [3:0]  cmd, rn, rd, rm;
  logic [11:0] imm12;
  logic [23:0] imm24;

  assign op    = ir_q[27:26];
  assign i_bit = ir_q[25];
  assign cmd   = ir_q[24:21];
  assign s_bit = ir_q[20];
  assign rn    = ir_q[19:16];
  assign rd    = ir_q[15:12];
  assign rm    = ir_q[3:0];
  assign imm12 = ir_q[11:0];
  assign imm24 = ir_q[23:0];

  // Second read port supplies Rm for data-processing, Rd (store data) for memory ops.
  logic [3:0]  rb_idx;
  logic [31:0] rn_val, rb_val;
  assign rb_idx = (op == OP_MEM) ? rd : rm;

  always_comb begin
    rn_val = '0;
    rb_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rn == 4'(i)) rn_val = rf_q[i];
      if (rb_idx == 4'(i)) rb_val = rf_q[i];
    end
  end

  logic [31:0] op2, alu_r, br_off;
  logic [32:0] add_r, sub_r;
  logic        alu_c, alu_v, cmd_known;

  assign op2    = i_bit ? {24'd0, ir_q[7:0]} : b_q;
  assign add_r  = {1'b0, a_q} + {1'b0, op2};
  assign sub_r  = {1'b0, a_q} + {1'b0, ~op2} + 33'd1;
  assign br_off = {{6{imm24[23]}}, imm24, 2'b00};

  // Logical ops carry the old CO/OVF through so the flag update can be uniform.
  always_comb begin
    alu_r     = op2;
    alu_c     = flags_q[1];
    alu_v     = flags_q[0];
    cmd_known = 1'b1;
    case (cmd)
      CMD_AND: alu_r = a_q & op2;
      CMD_ORR: alu_r = a_q | op2;
      CMD_MOV: alu_r = op2;
      CMD_ADD: begin
        alu_r = add_r[31:0];
        alu_c = add_r[32];
        alu_v = (a_q[31] == op2[31]) && (add_r[31] != a_q[31]);
      end
      CMD_SUB, CMD_CMP: begin
        alu_r = sub_r[31:0];
        alu_c = sub_r[32];
        alu_v = (a_q[31] != op2[31]) && (sub_r[31] != a_q[31]);
      end
      default: cmd_known = 1'b0;
    endcase
  end

  logic        rf_we;
  logic [31:0] wb_data;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    mdr_d   = mdr_q;
    out_d   = out_q;
    flags_d = flags_q;
    rf_we   = 1'b0;
    wb_data = (op == OP_MEM) ? mdr_q : out_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + MEM_AW'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rn_val;
        b_d     = rb_val;
        state_d = (op == OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_DP: begin
            out_d = alu_r;
            if (s_bit || cmd == CMD_CMP)
              flags_d = {alu_r[31], alu_r == 32'd0, alu_c, alu_v};
            state_d = (cmd == CMD_CMP) ? S_FETCH : S_WB;
          end
          OP_MEM: begin
            addr_d  = a_q[MEM_AW-1:0] + MEM_AW'(imm12);
            state_d = S_MEMACC;
          end
          OP_B: begin
            // pc_q already points at the instruction after the branch
            pc_d    = pc_q + br_off[MEM_AW-1:0];
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEMACC: begin
        if (mem_ready) begin
          if (s_bit) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we   = (op == OP_MEM) || (cmd_known && cmd != CMD_CMP);
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC[MEM_AW-1:0];
      addr_q  <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mdr_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mdr_q   <= mdr_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  // Indices >= NREG never match any entry, so such writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      for (int i = 0; i < NREG; i++)
        if (rd == 4'(i)) rf_q[i] <= wb_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ir_q[31:28], br_off};

  assign mem_req   = ~reset & ((state_q == S_FETCH) | (state_q == S_MEMACC));
  assign mem_we    = mem_req & (state_q == S_MEMACC) & ~s_bit;
  assign mem_addr  = ((state_q == S_MEMACC) ? addr_q : pc_q) & ~MEM_AW'(3);
  assign mem_wdata = b_q;
  assign out       = out_q;
  assign N         = flags_q[3];
  assign Z         = flags_q[2];
  assign CO        = flags_q[1];
  assign OVF       = flags_q[0];
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a wait-state memory model logs every
// handshake, and programs are checked against hand-computed cycles, addresses and flags.
module tb_multicycle_cpu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] out;
  logic        N, Z, CO, OVF, halted;

  multicycle_cpu #(.MEM_AW(16), .RESET_PC(32'h0003_0020), .NREG(16)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .out(out), .N(N), .Z(Z), .CO(CO), .OVF(OVF), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Memory model with wait_cfg wait cycles per access, decided on the falling edge.
  logic [31:0] mem [16384];
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          cyc = 0;
  logic [15:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wd;
  int          q_cyc[$];
  logic [15:0] q_addr[$];
  logic        q_we[$];
  logic [31:0] q_wd[$];
  int          e_cyc[$];
  logic [15:0] e_addr[$];
  logic        e_we[$];
  logic [31:0] e_wd[$];

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        cap_addr = mem_addr;
        cap_we   = mem_we;
        cap_wd   = mem_wdata;
      end else begin
        check_eq("hold_addr", 32'(mem_addr), 32'(cap_addr));
        check_eq("hold_we", 32'(mem_we), 32'(cap_we));
        if (cap_we) check_eq("hold_wdata", mem_wdata, cap_wd);
      end
      if (wcnt >= wait_cfg) begin
        mem_ready = 1'b1;
        wcnt = 0;
        if (mem_we) mem[mem_addr[15:2]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[15:2]];
        q_cyc.push_back(cyc);
        q_addr.push_back(mem_addr);
        q_we.push_back(mem_we);
        q_wd.push_back(mem_wdata);
        $display("mem cyc=%0d addr=0x%04h we=%0b wdata=0x%08h rdata=0x%08h",
                 cyc, mem_addr, mem_we, mem_wdata, mem_rdata);
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end
  end

  function automatic logic [31:0] dp(input logic i, input logic [3:0] cmd, input logic s,
                                     input logic [3:0] rn, input logic [3:0] rd, input logic [7:0] op2);
    return {4'hE, 2'b00, i, cmd, s, rn, rd, 4'h0, op2};
  endfunction

  function automatic logic [31:0] mm(input logic l, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] imm);
    return {4'hE, 2'b01, 1'b0, 4'h0, l, rn, rd, imm};
  endfunction

  function automatic logic [31:0] br(input logic [23:0] off);
    return {4'hE, 2'b10, 2'b00, off};
  endfunction

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc != c) check_eq("wait_cyc", 32'(cyc), 32'(c));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_req"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_out"}, out, 32'd0);
    check_eq({tag, "_flags"}, 32'({N, Z, CO, OVF}), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic expect_hs(input int c, input logic [15:0] a, input logic w, input logic [31:0] d);
    e_cyc.push_back(c);
    e_addr.push_back(a);
    e_we.push_back(w);
    e_wd.push_back(d);
  endtask

  task automatic clear_logs();
    q_cyc.delete(); q_addr.delete(); q_we.delete(); q_wd.delete();
    e_cyc.delete(); e_addr.delete(); e_we.delete(); e_wd.delete();
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_count"}, 32'(q_cyc.size()), 32'(e_cyc.size()));
    for (int k = 0; k < e_cyc.size() && k < q_cyc.size(); k++) begin
      check_eq($sformatf("%s_cyc%0d", tag, k), 32'(q_cyc[k]), 32'(e_cyc[k]));
      check_eq($sformatf("%s_addr%0d", tag, k), 32'(q_addr[k]), 32'(e_addr[k]));
      check_eq($sformatf("%s_we%0d", tag, k), 32'(q_we[k]), 32'(e_we[k]));
      if (e_we[k]) check_eq($sformatf("%s_wdata%0d", tag, k), q_wd[k], e_wd[k]);
    end
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = 32'd0;
    // Program 1: ALU, flags, loads/stores with waits, branches, wrap, HALT
    mem[16'h0020 >> 2] = dp(1'b1, 4'hD, 1'b0, 4'd0, 4'd1, 8'd5);    // MOV R1,#5
    mem[16'h0024 >> 2] = dp(1'b1, 4'hD, 1'b0, 4'd0, 4'd2, 8'd3);    // MOV R2,#3
    mem[16'h0028 >> 2] = dp(1'b0, 4'h2, 1'b1, 4'd1, 4'd3, 8'd2);    // SUBS R3,R1,R2
    mem[16'h002C >> 2] = dp(1'b0, 4'hA, 1'b0, 4'd2, 4'd0, 8'd1);    // CMP R2,R1
    mem[16'h0030 >> 2] = mm(1'b1, 4'd0, 4'd5, 12'h200);              // LDR R5,[R0,#0x200]
    mem[16'h0034 >> 2] = dp(1'b1, 4'h4, 1'b1, 4'd5, 4'd6, 8'd1);    // ADDS R6,R5,#1
    mem[16'h0038 >> 2] = dp(1'b0, 4'h4, 1'b0, 4'd6, 4'd7, 8'd6);    // ADD R7,R6,R6
    mem[16'h003C >> 2] = mm(1'b0, 4'd0, 4'd3, 12'h080);              // STR R3,[R0,#0x80]
    mem[16'h0040 >> 2] = mm(1'b1, 4'd0, 4'd4, 12'h080);              // LDR R4,[R0,#0x80]
    mem[16'h0044 >> 2] = mm(1'b0, 4'd0, 4'd4, 12'h084);              // STR R4,[R0,#0x84]
    mem[16'h0048 >> 2] = br(24'hFFFFF1);                             // B -> 0x10
    mem[16'h0010 >> 2] = br(24'hFFFFFE);                             // B -> 0x0C
    mem[16'h000C >> 2] = br(24'h003FFA);                             // B -> 0xFFF8
    mem[16'hFFF8 >> 2] = br(24'h000003);                             // B -> wraps to 0x08
    mem[16'h0008 >> 2] = {4'hE, 2'b11, 26'd0};                       // HALT
    mem[16'h0200 >> 2] = 32'h7FFF_FFFF;

    clear_logs();
    do_reset("rst0");
    wait_cyc(11);
    check_eq("sub_wb_req", 32'(mem_req), 32'd0);
    wait_cyc(12);
    check_eq("p1_req12", 32'(mem_req), 32'd1);
    check_eq("p1_pc12", 32'(mem_addr), 32'h002C);
    check_eq("subs_out", out, 32'd2);
    check_eq("subs_flags", 32'({N, Z, CO, OVF}), 32'b0010);
    wait_cyc(15);
    check_eq("cmp_out", out, 32'hFFFF_FFFE);
    check_eq("cmp_flags", 32'({N, Z, CO, OVF}), 32'b1000);
    wait_cyc(24);
    check_eq("adds_out", out, 32'h8000_0000);
    check_eq("adds_flags", 32'({N, Z, CO, OVF}), 32'b1001);
    wait_cyc(28);
    check_eq("add_nos_out", out, 32'd0);
    check_eq("add_nos_flags", 32'({N, Z, CO, OVF}), 32'b1001);
    wait_cfg = 3;
    wait_cyc(48);
    wait_cfg = 0;
    wait_cyc(66);
    check_eq("pre_halt", 32'(halted), 32'd0);
    for (int c = 67; c <= 80; c++) begin
      wait_cyc(c);
      check_eq($sformatf("halt_req_c%0d", c), 32'(mem_req), 32'd0);
      check_eq($sformatf("halted_c%0d", c), 32'(halted), 32'd1);
    end
    expect_hs(0,  16'h0020, 1'b0, 32'd0);
    expect_hs(4,  16'h0024, 1'b0, 32'd0);
    expect_hs(8,  16'h0028, 1'b0, 32'd0);
    expect_hs(12, 16'h002C, 1'b0, 32'd0);
    expect_hs(15, 16'h0030, 1'b0, 32'd0);
    expect_hs(18, 16'h0200, 1'b0, 32'd0);
    expect_hs(20, 16'h0034, 1'b0, 32'd0);
    expect_hs(24, 16'h0038, 1'b0, 32'd0);
    expect_hs(31, 16'h003C, 1'b0, 32'd0);
    expect_hs(37, 16'h0080, 1'b1, 32'd2);
    expect_hs(41, 16'h0040, 1'b0, 32'd0);
    expect_hs(47, 16'h0080, 1'b0, 32'd0);
    expect_hs(49, 16'h0044, 1'b0, 32'd0);
    expect_hs(52, 16'h0084, 1'b1, 32'd2);
    expect_hs(53, 16'h0048, 1'b0, 32'd0);
    expect_hs(56, 16'h0010, 1'b0, 32'd0);
    expect_hs(59, 16'h000C, 1'b0, 32'd0);
    expect_hs(62, 16'hFFF8, 1'b0, 32'd0);
    expect_hs(65, 16'h0008, 1'b0, 32'd0);
    check_log("p1");

    // Program 2: AND/ORR, CO set by CMP, then reset during a stalled store
    mem[16'h0020 >> 2] = dp(1'b1, 4'hD, 1'b0, 4'd0, 4'd1, 8'hF0);   // MOV R1,#0xF0
    mem[16'h0024 >> 2] = dp(1'b1, 4'hC, 1'b0, 4'd1, 4'd2, 8'h0F);   // ORR R2,R1,#0x0F
    mem[16'h0028 >> 2] = dp(1'b1, 4'h0, 1'b1, 4'd2, 4'd3, 8'h3C);   // ANDS R3,R2,#0x3C
    mem[16'h002C >> 2] = dp(1'b1, 4'hA, 1'b0, 4'd2, 4'd0, 8'd1);    // CMP R2,#1
    mem[16'h0030 >> 2] = mm(1'b0, 4'd0, 4'd3, 12'h100);              // STR R3,[R0,#0x100]
    clear_logs();
    do_reset("rst_halt");
    wait_cyc(0);
    check_eq("p2_first_fetch", 32'(mem_addr), 32'h0020);
    wait_cyc(8);
    check_eq("orr_out", out, 32'h0000_00FF);
    wait_cyc(12);
    check_eq("ands_out", out, 32'h0000_003C);
    check_eq("ands_flags", 32'({N, Z, CO, OVF}), 32'b0000);
    wait_cyc(15);
    check_eq("cmp2_out", out, 32'h0000_00FE);
    check_eq("cmp2_flags", 32'({N, Z, CO, OVF}), 32'b0010);
    wait_cyc(16);
    wait_cfg = 20;
    wait_cyc(20);
    check_eq("stall_req", 32'(mem_req), 32'd1);
    check_eq("stall_we", 32'(mem_we), 32'd1);
    check_eq("stall_addr", 32'(mem_addr), 32'h0100);
    check_eq("stall_wdata", mem_wdata, 32'h0000_003C);
    wait_cfg = 0;
    mem[16'h0020 >> 2] = mm(1'b0, 4'd0, 4'd3, 12'h104);              // STR R3,[R0,#0x104]
    mem[16'h0024 >> 2] = {4'hE, 2'b11, 26'd0};                       // HALT
    do_reset("rst_mem");
    clear_logs();

    // Program 3: PC back at reset vector and registers cleared
    wait_cyc(6);
    check_eq("p3_halted", 32'(halted), 32'd1);
    expect_hs(0, 16'h0020, 1'b0, 32'd0);
    expect_hs(3, 16'h0104, 1'b1, 32'd0);
    expect_hs(4, 16'h0024, 1'b0, 32'd0);
    check_log("p3");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
